lcd_bus_decoder: RTL and testbench

- Receiving end of the HD44780-style 8-bit LCD bus that our LCD controller drives.
- Snoops LCD_ON/LCD_EN/LCD_RS/LCD_RW/LCD_DATA and decodes each falling-edge write into a command or a character.
- Maintains a 2-line shadow of the visible DDRAM and exposes it through a read port.
- Used as a bench checker and to mirror the pill-status screen onto other outputs (7-seg, UART).

---
 rtl/lcd_pkg.sv | 61 ++++++
 rtl/lcd_ddram_shadow.sv | 65 ++++++
 rtl/lcd_bus_decoder.sv | 216 +++++++++++++++++++++
 tb/tb_lcd_bus_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/lcd_pkg.sv
// Shared HD44780 bus constants and command classification, used by the decoder
// and by the LCD controller that drives the bus.
package lcd_pkg;

    localparam logic [6:0] LINE2_BASE = 7'h40;
    localparam logic [6:0] LINE1_LAST = 7'h27;
    localparam logic [6:0] LINE2_LAST = 7'h67;
    localparam logic [7:0] CHAR_BLANK = 8'h20;

    // Command-class masks: the class is the highest set bit of the command byte.
    localparam logic [7:0] M_SET_DDRAM = 8'h80;
    localparam logic [7:0] M_SET_CGRAM = 8'h40;
    localparam logic [7:0] M_FUNC_SET  = 8'h20;
    localparam logic [7:0] M_SHIFT     = 8'h10;
    localparam logic [7:0] M_DISP_CTRL = 8'h08;
    localparam logic [7:0] M_ENTRY     = 8'h04;
    localparam logic [7:0] M_HOME      = 8'h02;
    localparam logic [7:0] M_CLEAR     = 8'h01;

    typedef enum logic [3:0] {
        CMD_NOP,
        CMD_CLEAR,
        CMD_HOME,
        CMD_ENTRY,
        CMD_DISP,
        CMD_SHIFT,
        CMD_FUNC,
        CMD_CGRAM,
        CMD_DDRAM
    } cmd_class_e;

    function automatic cmd_class_e cmd_class(input logic [7:0] c);
        cmd_class_e r;
        if      ((c & M_SET_DDRAM) != 8'h00) r = CMD_DDRAM;
        else if ((c & M_SET_CGRAM) != 8'h00) r = CMD_CGRAM;
        else if ((c & M_FUNC_SET)  != 8'h00) r = CMD_FUNC;
        else if ((c & M_SHIFT)     != 8'h00) r = CMD_SHIFT;
        else if ((c & M_DISP_CTRL) != 8'h00) r = CMD_DISP;
        else if ((c & M_ENTRY)     != 8'h00) r = CMD_ENTRY;
        else if ((c & M_HOME)      != 8'h00) r = CMD_HOME;
        else if ((c & M_CLEAR)     != 8'h00) r = CMD_CLEAR;
        else                                 r = CMD_NOP;
        return r;
    endfunction

    // One cursor step on the 2-line DDRAM map (0x00..0x27, 0x40..0x67).
    function automatic logic [6:0] addr_step(input logic [6:0] a, input logic inc);
        logic [6:0] r;
        if (inc) begin
            if (a == LINE1_LAST)      r = LINE2_BASE;
            else if (a == LINE2_LAST) r = 7'h00;
            else                      r = a + 7'd1;
        end else begin
            if (a == 7'h00)           r = LINE2_LAST;
            else if (a == LINE2_BASE) r = LINE1_LAST;
            else                      r = a - 7'd1;
        end
        return r;
    endfunction

endpackage

// File: rtl/lcd_ddram_shadow.sv
// Shadow copy of the visible DDRAM: character buffer, valid bits, DDRAM
// address to buffer index mapping and a registered read port.
module lcd_ddram_shadow
    import lcd_pkg::*;
#(
    parameter int NUM_COLS = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       wr_en,
    input  logic [6:0] wr_addr,
    input  logic [7:0] wr_data,
    input  logic       clear,
    input  logic [4:0] rd_idx,
    output logic [7:0] rd_char
);

    localparam int DEPTH = 2 * NUM_COLS;

    logic [7:0]       chars_q [DEPTH];
    logic [DEPTH-1:0] valid_q, valid_d;
    logic [7:0]       rd_char_q, rd_char_d;
    logic             wr_hit;
    logic [4:0]       wr_idx;

    always_comb begin
        wr_hit = 1'b0;
        wr_idx = '0;
        if (wr_addr < 7'(NUM_COLS)) begin
            wr_hit = 1'b1;
            wr_idx = 5'(wr_addr);
        end else if (wr_addr >= LINE2_BASE && wr_addr < LINE2_BASE + 7'(NUM_COLS)) begin
            wr_hit = 1'b1;
            wr_idx = 5'(wr_addr - LINE2_BASE + 7'(NUM_COLS));
        end
    end

    always_comb begin
        valid_d = valid_q;
        if (clear)
            valid_d = '0;
        else if (wr_en && wr_hit)
            valid_d[wr_idx] = 1'b1;
        // Read sees pre-write contents, so a same-cycle write returns the old value.
        rd_char_d = valid_q[rd_idx] ? chars_q[rd_idx] : CHAR_BLANK;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            valid_q   <= '0;
            rd_char_q <= 8'h00;
        end else begin
            valid_q   <= valid_d;
            rd_char_q <= rd_char_d;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en && wr_hit)
            chars_q[wr_idx] <= wr_data;
    end

    assign rd_char = rd_char_q;

endmodule

// File: rtl/lcd_bus_decoder.sv
// Snoops an HD44780 8-bit bus and decodes falling-edge writes into commands and
// characters. Optional frame counting is built when LCD_DEC_FRAME_EN is defined.
module lcd_bus_decoder
    import lcd_pkg::*;
#(
    parameter int NUM_COLS       = 16,
    parameter int INIT_FUNC_SETS = 3
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        LCD_ON,
    input  logic        LCD_EN,
    input  logic        LCD_RS,
    input  logic        LCD_RW,
    input  logic [7:0]  LCD_DATA,
    input  logic [4:0]  readAddr,
    output logic [7:0]  readChar,
    output logic [6:0]  cursorAddr,
    output logic        displayOn,
    output logic        initDone,
    output logic        cmdStrobe,
    output logic        charStrobe,
    output logic [7:0]  lastCommand,
    output logic        protocolError,
    output logic        frameStrobe,
    output logic [15:0] frameCount
);

    localparam int FS_W = $clog2(INIT_FUNC_SETS + 1);

    typedef enum logic {WAIT_INIT, READY} state_e;

    state_e          state_q, state_d;
    logic [FS_W-1:0] fs_count_q, fs_count_d;
    logic [6:0]      addr_q, addr_d;
    logic            inc_q, inc_d;
    logic            cg_mode_q, cg_mode_d;
    logic            disp_on_q, disp_on_d;
    logic            init_done_q, init_done_d;
    logic            cmd_strobe_q, cmd_strobe_d;
    logic            char_strobe_q, char_strobe_d;
    logic [7:0]      last_cmd_q, last_cmd_d;
    logic            perr_q, perr_d;

    logic            en_q, rs_q, rw_q;
    logic [7:0]      data_q;
    logic            bus_event;
    logic            shadow_wr, shadow_clr;
    cmd_class_e      cls;

    // The write completes on EN high->low; RS/RW/DATA come from the last EN-high cycle.
    assign bus_event = en_q && !LCD_EN && LCD_ON;
    assign cls       = cmd_class(data_q);

    always_comb begin
        state_d       = state_q;
        fs_count_d    = fs_count_q;
        addr_d        = addr_q;
        inc_d         = inc_q;
        cg_mode_d     = cg_mode_q;
        disp_on_d     = disp_on_q;
        init_done_d   = init_done_q;
        cmd_strobe_d  = 1'b0;
        char_strobe_d = 1'b0;
        last_cmd_d    = last_cmd_q;
        perr_d        = perr_q;
        shadow_wr     = 1'b0;
        shadow_clr    = 1'b0;

        if (bus_event) begin
            if (rw_q) begin
                perr_d = 1'b1;
            end else begin
                case (state_q)
                    WAIT_INIT: begin
                        if (!rs_q && cls == CMD_FUNC) begin
                            fs_count_d   = fs_count_q + FS_W'(1);
                            cmd_strobe_d = 1'b1;
                            last_cmd_d   = data_q;
                            if (fs_count_d == FS_W'(INIT_FUNC_SETS)) begin
                                state_d     = READY;
                                init_done_d = 1'b1;
                            end
                        end else begin
                            perr_d = 1'b1;
                        end
                    end
                    READY: begin
                        if (!rs_q) begin
                            cmd_strobe_d = 1'b1;
                            last_cmd_d   = data_q;
                            case (cls)
                                CMD_DDRAM: begin
                                    addr_d    = data_q[6:0];
                                    cg_mode_d = 1'b0;
                                end
                                CMD_CGRAM: cg_mode_d = 1'b1;
                                CMD_SHIFT: if (!data_q[3]) addr_d = addr_step(addr_q, data_q[2]);
                                CMD_DISP:  disp_on_d = data_q[2];
                                CMD_ENTRY: inc_d = data_q[1];
                                CMD_HOME:  addr_d = 7'h00;
                                CMD_CLEAR: begin
                                    shadow_clr = 1'b1;
                                    addr_d     = 7'h00;
                                    inc_d      = 1'b1;
                                end
                                default: ;
                            endcase
                        end else if (!cg_mode_q) begin
                            // Off-screen addresses still strobe and step; the shadow drops them.
                            shadow_wr     = 1'b1;
                            char_strobe_d = 1'b1;
                            addr_d        = addr_step(addr_q, inc_q);
                        end
                    end
                    default: ;
                endcase
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q       <= WAIT_INIT;
            fs_count_q    <= '0;
            addr_q        <= 7'h00;
            inc_q         <= 1'b1;
            cg_mode_q     <= 1'b0;
            disp_on_q     <= 1'b0;
            init_done_q   <= 1'b0;
            cmd_strobe_q  <= 1'b0;
            char_strobe_q <= 1'b0;
            last_cmd_q    <= 8'h00;
            perr_q        <= 1'b0;
            en_q          <= 1'b0;
        end else begin
            state_q       <= state_d;
            fs_count_q    <= fs_count_d;
            addr_q        <= addr_d;
            inc_q         <= inc_d;
            cg_mode_q     <= cg_mode_d;
            disp_on_q     <= disp_on_d;
            init_done_q   <= init_done_d;
            cmd_strobe_q  <= cmd_strobe_d;
            char_strobe_q <= char_strobe_d;
            last_cmd_q    <= last_cmd_d;
            perr_q        <= perr_d;
            en_q          <= LCD_EN;
        end
    end

    always_ff @(posedge clk) begin
        rs_q   <= LCD_RS;
        rw_q   <= LCD_RW;
        data_q <= LCD_DATA;
    end

    lcd_ddram_shadow #(
        .NUM_COLS (NUM_COLS)
    ) u_shadow (
        .clk     (clk),
        .reset   (reset),
        .wr_en   (shadow_wr),
        .wr_addr (addr_q),
        .wr_data (data_q),
        .clear   (shadow_clr),
        .rd_idx  (readAddr),
        .rd_char (readChar)
    );

`ifdef LCD_DEC_FRAME_EN
    logic        frame_end;
    logic        frame_pending_q, frame_pending_d;
    logic        frame_strobe_q, frame_strobe_d;
    logic [15:0] frame_count_q, frame_count_d;

    // A frame closes on a return-to-origin command once something was written.
    always_comb begin
        frame_end = bus_event && !rw_q && !rs_q && state_q == READY && frame_pending_q &&
                    ((cls == CMD_DDRAM && data_q[6:0] == 7'h00) ||
                     cls == CMD_HOME || cls == CMD_CLEAR);
        frame_pending_d = frame_end ? 1'b0 : (frame_pending_q || char_strobe_d);
        frame_strobe_d  = frame_end;
        frame_count_d   = frame_count_q;
        if (frame_end && frame_count_q != 16'hFFFF)
            frame_count_d = frame_count_q + 16'd1;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            frame_pending_q <= 1'b0;
            frame_strobe_q  <= 1'b0;
            frame_count_q   <= 16'h0000;
        end else begin
            frame_pending_q <= frame_pending_d;
            frame_strobe_q  <= frame_strobe_d;
            frame_count_q   <= frame_count_d;
        end
    end

    assign frameStrobe = frame_strobe_q;
    assign frameCount  = frame_count_q;
`else
    assign frameStrobe = 1'b0;
    assign frameCount  = 16'h0000;
`endif

    assign cursorAddr    = addr_q;
    assign displayOn     = disp_on_q;
    assign initDone      = init_done_q;
    assign cmdStrobe     = cmd_strobe_q;
    assign charStrobe    = char_strobe_q;
    assign lastCommand   = last_cmd_q;
    assign protocolError = perr_q;

endmodule

// File: tb/tb_lcd_bus_decoder.sv
// Directed bench for lcd_bus_decoder: drives HD44780 writes on the bus and
// compares decoder outputs against hand-computed values.
module tb_lcd_bus_decoder;

    localparam int NUM_COLS = 16;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        LCD_ON = 1'b0;
    logic        LCD_EN = 1'b0;
    logic        LCD_RS = 1'b0;
    logic        LCD_RW = 1'b0;
    logic [7:0]  LCD_DATA = 8'h00;
    logic [4:0]  readAddr = 5'd0;
    logic [7:0]  readChar;
    logic [6:0]  cursorAddr;
    logic        displayOn;
    logic        initDone;
    logic        cmdStrobe;
    logic        charStrobe;
    logic [7:0]  lastCommand;
    logic        protocolError;
    logic        frameStrobe;
    logic [15:0] frameCount;

    int n_chk = 0;
    int n_err = 0;

    lcd_bus_decoder #(
        .NUM_COLS       (NUM_COLS),
        .INIT_FUNC_SETS (3)
    ) dut (
        .clk           (clk),
        .reset         (reset),
        .LCD_ON        (LCD_ON),
        .LCD_EN        (LCD_EN),
        .LCD_RS        (LCD_RS),
        .LCD_RW        (LCD_RW),
        .LCD_DATA      (LCD_DATA),
        .readAddr      (readAddr),
        .readChar      (readChar),
        .cursorAddr    (cursorAddr),
        .displayOn     (displayOn),
        .initDone      (initDone),
        .cmdStrobe     (cmdStrobe),
        .charStrobe    (charStrobe),
        .lastCommand   (lastCommand),
        .protocolError (protocolError),
        .frameStrobe   (frameStrobe),
        .frameCount    (frameCount)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Called on a negedge; returns on the negedge after the decoder has registered the write.
    task automatic bus(input logic rs, input logic rw, input logic on, input logic [7:0] d);
        LCD_RS   = rs;
        LCD_RW   = rw;
        LCD_ON   = on;
        LCD_DATA = d;
        LCD_EN   = 1'b1;
        @(negedge clk);
        LCD_EN = 1'b0;
        @(negedge clk);
        LCD_ON = 1'b1;
    endtask

    task automatic cmd(input logic [7:0] d);
        bus(1'b0, 1'b0, 1'b1, d);
    endtask

    task automatic wr(input logic [7:0] d);
        bus(1'b1, 1'b0, 1'b1, d);
    endtask

    task automatic rd(input string tag, input logic [4:0] idx, input logic [7:0] exp);
        readAddr = idx;
        @(negedge clk);
        chk(tag, 16'(readChar), 16'(exp));
    endtask

    task automatic do_reset();
        reset  = 1'b1;
        LCD_EN = 1'b0;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
    endtask

    task automatic do_init();
        cmd(8'h38);
        cmd(8'h38);
        cmd(8'h38);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        @(negedge clk);
        @(negedge clk);
        chk("rst_initDone", 16'(initDone), 16'h0);
        chk("rst_perr", 16'(protocolError), 16'h0);
        chk("rst_cursor", 16'(cursorAddr), 16'h0);
        chk("rst_readChar", 16'(readChar), 16'h0);
        chk("rst_cmdStrobe", 16'(cmdStrobe), 16'h0);
        chk("rst_lastCmd", 16'(lastCommand), 16'h0);
        chk("rst_displayOn", 16'(displayOn), 16'h0);
        LCD_ON = 1'b1;
        reset  = 1'b0;
        @(negedge clk);
        chk("post_rst_readChar", 16'(readChar), 16'h20);

        cmd(8'h38);
        cmd(8'h38);
        chk("init_after2", 16'(initDone), 16'h0);
        cmd(8'h38);
        chk("init_after3", 16'(initDone), 16'h1);
        chk("init_cmdStrobe", 16'(cmdStrobe), 16'h1);
        chk("init_lastCmd", 16'(lastCommand), 16'h38);
        chk("init_perr", 16'(protocolError), 16'h0);

        do_reset();
        wr(8'h41);
        chk("preinit_perr", 16'(protocolError), 16'h1);
        chk("preinit_charStrobe", 16'(charStrobe), 16'h0);
        rd("preinit_idx0", 5'd0, 8'h20);

        do_reset();
        chk("reset_clears_perr", 16'(protocolError), 16'h0);
        do_init();
        cmd(8'h01);
        cmd(8'h06);
        wr(8'h50);
        chk("wrP_charStrobe", 16'(charStrobe), 16'h1);
        wr(8'h3A);
        chk("wr2_cursor", 16'(cursorAddr), 16'h02);
        rd("idx0_P", 5'd0, 8'h50);
        rd("idx1_colon", 5'd1, 8'h3A);

        cmd(8'hC0);
        wr(8'h33);
        chk("line2_cursor", 16'(cursorAddr), 16'h41);
        rd("idx16_3", 5'd16, 8'h33);

        cmd(8'hA7);
        chk("setA7_cursor", 16'(cursorAddr), 16'h27);
        wr(8'h58);
        chk("wrap27_strobe", 16'(charStrobe), 16'h1);
        chk("wrap27_cursor", 16'(cursorAddr), 16'h40);
        cmd(8'hE7);
        wr(8'h59);
        chk("wrap67_cursor", 16'(cursorAddr), 16'h00);
        rd("offscreen_idx0", 5'd0, 8'h50);

        cmd(8'h80);
        cmd(8'h10);
        chk("left_from0", 16'(cursorAddr), 16'h67);
        cmd(8'h14);
        chk("right_from67", 16'(cursorAddr), 16'h00);
        cmd(8'h18);
        chk("shift_display_noop", 16'(cursorAddr), 16'h00);

        cmd(8'h04);
        cmd(8'hC0);
        wr(8'h4B);
        chk("dec_wrap40", 16'(cursorAddr), 16'h27);
        rd("idx16_K", 5'd16, 8'h4B);
        cmd(8'h06);

        cmd(8'h80);
        cmd(8'h40);
        chk("cg_lastCmd", 16'(lastCommand), 16'h40);
        wr(8'hFF);
        chk("cg_no_strobe", 16'(charStrobe), 16'h0);
        chk("cg_cursor", 16'(cursorAddr), 16'h00);
        rd("cg_shadow", 5'd0, 8'h50);
        cmd(8'h80);

        cmd(8'h0C);
        chk("disp_on", 16'(displayOn), 16'h1);
        cmd(8'h08);
        chk("disp_off", 16'(displayOn), 16'h0);

        bus(1'b0, 1'b0, 1'b0, 8'h0C);
        chk("lcdoff_no_strobe", 16'(cmdStrobe), 16'h0);
        chk("lcdoff_disp", 16'(displayOn), 16'h0);

        cmd(8'h01);
        chk("clear_cursor", 16'(cursorAddr), 16'h00);
        rd("clear_idx0", 5'd0, 8'h20);
        rd("clear_idx16", 5'd16, 8'h20);

        bus(1'b0, 1'b1, 1'b1, 8'h0C);
        chk("rw_perr", 16'(protocolError), 16'h1);
        chk("rw_ignored", 16'(displayOn), 16'h0);
        cmd(8'h38);
        chk("rw_sticky", 16'(protocolError), 16'h1);
        do_reset();
        chk("rw_reset", 16'(protocolError), 16'h0);

`ifdef LCD_DEC_FRAME_EN
        do_init();
        for (int pass = 0; pass < 2; pass++) begin
            for (int i = 0; i < NUM_COLS; i++)
                wr(8'h41 + 8'(i));
            cmd(8'h80);
            chk("frame_strobe", 16'(frameStrobe), 16'h1);
        end
        chk("frame_count", frameCount, 16'h0002);
        cmd(8'h80);
        chk("frame_no_writes", frameCount, 16'h0002);
`else
        do_init();
        wr(8'h41);
        cmd(8'h80);
        chk("frame_strobe_off", 16'(frameStrobe), 16'h0);
        chk("frame_count_off", frameCount, 16'h0000);
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
